// File: rtl/instruction_decode_stage.sv
// Registered decode stage between fetch and execute: valid/ready on both sides,
// a circular return-address stack and a post-transfer squash counter.
module instruction_decode_stage #(
   parameter int DATA_W       = 16,
   parameter int ADDR_W       = 16,
   parameter int REG_AW       = 5,
   parameter int MEM_AW       = 10,
   parameter int RAS_DEPTH    = 8,
   parameter int SQUASH_SLOTS = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_W+4:0]            ins,
   input  logic [ADDR_W-1:0]            ins_addr,
   input  logic [4:0]                   flags,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         a_ce,
   output logic                         regs_ce,
   output logic                         flags_ce,
   output logic                         mem_we,
   output logic                         load_pc,
   output logic                         pc_source,
   output logic                         block_cy_ov,
   output logic [1:0]                   arg_source,
   output logic [2:0]                   opcode,
   output logic [ADDR_W-1:0]            new_pc,
   output logic [REG_AW-1:0]            regs_addr,
   output logic [MEM_AW-1:0]            mem_addr,
   output logic [DATA_W-1:0]            instant,
   output logic [$clog2(RAS_DEPTH):0]   ras_count,
   output logic                         ras_overflow,
   output logic                         ras_underflow
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [4:0]        op;
   logic [DATA_W-1:0] payload;
   logic              accept;
   logic              drop;
   logic [1:0]        squash_cnt;
   logic [PTR_W-1:0]  ras_ptr;
   logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
   logic [ADDR_W-1:0] ras_top;
   logic [ADDR_W-1:0] ret_addr;
   logic              unused_flags;

   logic              d_a_ce, d_regs_ce, d_flags_ce, d_mem_we;
   logic              d_load_pc, d_pc_source, d_block_cy_ov;
   logic [1:0]        d_arg_source;
   logic [ADDR_W-1:0] d_new_pc;
   logic [DATA_W-1:0] d_instant;
   logic              do_push, do_pop, d_under;

   assign op           = ins[DATA_W+4:DATA_W];
   assign payload      = ins[DATA_W-1:0];
   assign in_ready     = !out_valid || out_ready;
   assign accept       = in_valid && in_ready;
   assign drop         = squash_cnt != 2'd0;
   assign ras_top      = ras_mem[ras_ptr - PTR_W'(1)];
   assign ret_addr     = ins_addr + ADDR_W'(1);
   assign unused_flags = ^flags[3:1];

   always_comb begin
      d_a_ce        = 1'b0;
      d_regs_ce     = 1'b0;
      d_flags_ce    = 1'b0;
      d_mem_we      = 1'b0;
      d_load_pc     = 1'b0;
      d_pc_source   = 1'b0;
      d_block_cy_ov = 1'b0;
      d_arg_source  = 2'b00;
      d_new_pc      = payload[ADDR_W-1:0];
      d_instant     = DATA_W'(1);
      do_push       = 1'b0;
      do_pop        = 1'b0;
      d_under       = 1'b0;
      case (op)
         5'b00000, 5'b00100, 5'b01000, 5'b01100, 5'b10000, 5'b10100: begin
            d_a_ce     = 1'b1;
            d_flags_ce = 1'b1;
         end
         5'b00001, 5'b00101: begin
            d_a_ce        = 1'b1;
            d_flags_ce    = 1'b1;
            d_arg_source  = 2'b01;
            d_block_cy_ov = 1'b1;
         end
         5'b01001: d_load_pc = 1'b1;
         5'b01101: begin
            d_load_pc = 1'b1;
            do_push   = 1'b1;
         end
         5'b01010: d_load_pc = flags[4];
         5'b01110: begin
            d_load_pc = flags[4];
            do_push   = flags[4];
         end
         5'b01011: d_load_pc = flags[0];
         5'b01111: begin
            d_load_pc = flags[0];
            do_push   = flags[0];
         end
         5'b10001: begin
            // An empty stack turns RET into a NOP that only raises the sticky flag
            if (ras_count == '0) begin
               d_under = 1'b1;
            end else begin
               d_load_pc   = 1'b1;
               d_pc_source = 1'b1;
               d_new_pc    = ras_top;
               do_pop      = 1'b1;
            end
         end
         5'b11100, 5'b11101, 5'b11110: begin
            d_a_ce       = 1'b1;
            d_instant    = payload;
            d_arg_source = op[1:0];
         end
         5'b11001: d_regs_ce = 1'b1;
         5'b11010: d_mem_we  = 1'b1;
         default: ;
      endcase
   end

   // When full, ras_ptr already points at the oldest entry, so a push overwrites it
   always_ff @(posedge clk) begin
      if (accept && !drop && do_push) ras_mem[ras_ptr] <= ret_addr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid     <= 1'b0;
         a_ce          <= 1'b0;
         regs_ce       <= 1'b0;
         flags_ce      <= 1'b0;
         mem_we        <= 1'b0;
         load_pc       <= 1'b0;
         pc_source     <= 1'b0;
         block_cy_ov   <= 1'b0;
         arg_source    <= 2'b00;
         opcode        <= 3'b000;
         new_pc        <= '0;
         regs_addr     <= '0;
         mem_addr      <= '0;
         instant       <= DATA_W'(1);
         ras_count     <= '0;
         ras_overflow  <= 1'b0;
         ras_underflow <= 1'b0;
         squash_cnt    <= 2'd0;
         ras_ptr       <= '0;
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (accept) begin
            if (drop) begin
               squash_cnt <= squash_cnt - 2'd1;
            end else begin
               out_valid   <= 1'b1;
               a_ce        <= d_a_ce;
               regs_ce     <= d_regs_ce;
               flags_ce    <= d_flags_ce;
               mem_we      <= d_mem_we;
               load_pc     <= d_load_pc;
               pc_source   <= d_pc_source;
               block_cy_ov <= d_block_cy_ov;
               arg_source  <= d_arg_source;
               opcode      <= op[4:2];
               new_pc      <= d_new_pc;
               regs_addr   <= payload[REG_AW-1:0];
               mem_addr    <= payload[MEM_AW-1:0];
               instant     <= d_instant;
               if (d_load_pc) squash_cnt <= 2'(SQUASH_SLOTS);
               if (do_push) begin
                  ras_ptr <= ras_ptr + PTR_W'(1);
                  if (ras_count == CNT_W'(RAS_DEPTH)) ras_overflow <= 1'b1;
                  else ras_count <= ras_count + CNT_W'(1);
               end
               if (do_pop) begin
                  ras_ptr   <= ras_ptr - PTR_W'(1);
                  ras_count <= ras_count - CNT_W'(1);
               end
               if (d_under) ras_underflow <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Scoreboard bench for instruction_decode_stage: two instances (no squash and
// one squash slot) share stimulus; a monitor pops expected bundles on consumption.
module tb_instruction_decode_stage;

   typedef struct packed {
      logic [6:0]  ctl;
      logic [1:0]  src;
      logic [2:0]  opc;
      logic [15:0] npc;
      logic [4:0]  radr;
      logic [9:0]  madr;
      logic [15:0] inst;
      logic [3:0]  rc;
      logic        ovf;
      logic        unf;
   } bundle_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid0, in_valid1;
   logic        in_ready0, in_ready1;
   logic [20:0] ins;
   logic [15:0] ins_addr;
   logic [4:0]  flags;
   logic        out_ready;
   logic        out_valid0, out_valid1;

   logic        a_ce0, regs_ce0, flags_ce0, mem_we0, load_pc0, pc_source0, block_cy_ov0;
   logic        a_ce1, regs_ce1, flags_ce1, mem_we1, load_pc1, pc_source1, block_cy_ov1;
   logic [1:0]  arg_source0, arg_source1;
   logic [2:0]  opcode0, opcode1;
   logic [15:0] new_pc0, new_pc1, instant0, instant1;
   logic [4:0]  regs_addr0, regs_addr1;
   logic [9:0]  mem_addr0, mem_addr1;
   logic [3:0]  ras_count0, ras_count1;
   logic        ras_overflow0, ras_overflow1, ras_underflow0, ras_underflow1;

   bundle_t act0, act1;
   bundle_t q0[$];
   bundle_t q1[$];
   int      vectors = 0;
   int      miscompares = 0;

   assign act0 = {a_ce0, regs_ce0, flags_ce0, mem_we0, load_pc0, pc_source0, block_cy_ov0,
                  arg_source0, opcode0, new_pc0, regs_addr0, mem_addr0, instant0,
                  ras_count0, ras_overflow0, ras_underflow0};
   assign act1 = {a_ce1, regs_ce1, flags_ce1, mem_we1, load_pc1, pc_source1, block_cy_ov1,
                  arg_source1, opcode1, new_pc1, regs_addr1, mem_addr1, instant1,
                  ras_count1, ras_overflow1, ras_underflow1};

   instruction_decode_stage #(.SQUASH_SLOTS(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
      .ins(ins), .ins_addr(ins_addr), .flags(flags),
      .out_valid(out_valid0), .out_ready(out_ready),
      .a_ce(a_ce0), .regs_ce(regs_ce0), .flags_ce(flags_ce0), .mem_we(mem_we0),
      .load_pc(load_pc0), .pc_source(pc_source0), .block_cy_ov(block_cy_ov0),
      .arg_source(arg_source0), .opcode(opcode0), .new_pc(new_pc0),
      .regs_addr(regs_addr0), .mem_addr(mem_addr0), .instant(instant0),
      .ras_count(ras_count0), .ras_overflow(ras_overflow0), .ras_underflow(ras_underflow0)
   );

   instruction_decode_stage #(.SQUASH_SLOTS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .ins(ins), .ins_addr(ins_addr), .flags(flags),
      .out_valid(out_valid1), .out_ready(out_ready),
      .a_ce(a_ce1), .regs_ce(regs_ce1), .flags_ce(flags_ce1), .mem_we(mem_we1),
      .load_pc(load_pc1), .pc_source(pc_source1), .block_cy_ov(block_cy_ov1),
      .arg_source(arg_source1), .opcode(opcode1), .new_pc(new_pc1),
      .regs_addr(regs_addr1), .mem_addr(mem_addr1), .instant(instant1),
      .ras_count(ras_count1), .ras_overflow(ras_overflow1), .ras_underflow(ras_underflow1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ctl = {a_ce, regs_ce, flags_ce, mem_we, load_pc, pc_source, block_cy_ov}
   function automatic bundle_t mk(input logic [4:0] op, input logic [15:0] pl,
                                  input logic [6:0] ctl, input logic [1:0] src,
                                  input logic [15:0] npc, input logic [15:0] inst,
                                  input logic [3:0] rc, input logic ovf, input logic unf);
      bundle_t b;
      b.ctl  = ctl;
      b.src  = src;
      b.opc  = op[4:2];
      b.npc  = npc;
      b.radr = pl[4:0];
      b.madr = pl[9:0];
      b.inst = inst;
      b.rc   = rc;
      b.ovf  = ovf;
      b.unf  = unf;
      return b;
   endfunction

   task automatic check_output(input string name, input bundle_t act, input bundle_t exp);
      bundle_t a = act;
      bundle_t e = exp;
      vectors++;
      if (!e.ctl[2]) begin
         a.npc = '0;
         e.npc = '0;
      end
      if (a !== e) begin
         miscompares++;
         $display("[TB] FAIL %s: got ctl=%b src=%b opc=%b npc=%h radr=%h madr=%h inst=%h rc=%0d ovf=%b unf=%b, expected ctl=%b src=%b opc=%b npc=%h radr=%h madr=%h inst=%h rc=%0d ovf=%b unf=%b",
                  name, a.ctl, a.src, a.opc, a.npc, a.radr, a.madr, a.inst, a.rc, a.ovf, a.unf,
                  e.ctl, e.src, e.opc, e.npc, e.radr, e.madr, e.inst, e.rc, e.ovf, e.unf);
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input bit sel, input logic [4:0] op, input logic [15:0] pl,
                                 input logic [15:0] addr, input logic [4:0] f,
                                 input bit has_exp, input bundle_t e);
      int budget = 0;
      ins      = {op, pl};
      ins_addr = addr;
      flags    = f;
      if (sel) in_valid1 = 1'b1;
      else     in_valid0 = 1'b1;
      while (!(sel ? in_ready1 : in_ready0) && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 50) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL accept timeout: in_ready stayed 0 for op %b", op);
      end else if (has_exp) begin
         if (sel) q1.push_back(e);
         else     q0.push_back(e);
      end
      @(negedge clk);
      in_valid0 = 1'b0;
      in_valid1 = 1'b0;
   endtask

   // A bundle presented with out_ready high is consumed at the coming edge
   always begin
      @(negedge clk);
      #1;
      if (rst_n && out_valid0 && out_ready) begin
         if (q0.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL dut0 unexpected bundle: got opcode %b, expected none", opcode0);
         end else check_output("dut0 bundle", act0, q0.pop_front());
      end
      if (rst_n && out_valid1 && out_ready) begin
         if (q1.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL dut1 unexpected bundle: got opcode %b, expected none", opcode1);
         end else check_output("dut1 bundle", act1, q1.pop_front());
      end
   end

   initial begin
      bundle_t none;
      bundle_t ldi_exp;
      none      = '0;
      rst_n     = 1'b0;
      in_valid0 = 1'b0;
      in_valid1 = 1'b0;
      out_ready = 1'b1;
      ins       = '0;
      ins_addr  = '0;
      flags     = '0;
      repeat (3) @(negedge clk);
      check_output("reset bundle", act0, mk(5'b00000, 16'h0000, 7'b0, 2'b00, 16'h0, 16'h0001, 4'd0, 1'b0, 1'b0));
      check_val("reset out_valid", 32'(out_valid0), 32'd0);
      check_val("reset new_pc", 32'(new_pc0), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("in_ready after reset", 32'(in_ready0), 32'd1);

      // No-squash instance: ALU, CALL then RET back to back
      apply_stimulus(0, 5'b00100, 16'h1234, 16'h0000, 5'b0, 1, mk(5'b00100, 16'h1234, 7'b1010000, 2'b00, 16'h0, 16'h0001, 4'd1 - 4'd1, 1'b0, 1'b0));
      apply_stimulus(0, 5'b01101, 16'h0040, 16'h0010, 5'b0, 1, mk(5'b01101, 16'h0040, 7'b0000100, 2'b00, 16'h0040, 16'h0001, 4'd1, 1'b0, 1'b0));
      apply_stimulus(0, 5'b10001, 16'h0000, 16'h0041, 5'b0, 1, mk(5'b10001, 16'h0000, 7'b0000110, 2'b00, 16'h0011, 16'h0001, 4'd0, 1'b0, 1'b0));

      // Nine calls into an eight-deep stack, then unwind past the bottom
      for (int i = 0; i < 9; i++)
         apply_stimulus(0, 5'b01101, 16'h0100 + 16'(i), 16'(i), 5'b0, 1,
                        mk(5'b01101, 16'h0100 + 16'(i), 7'b0000100, 2'b00, 16'h0100 + 16'(i), 16'h0001,
                           (i < 8) ? 4'(i + 1) : 4'd8, (i == 8), 1'b0));
      for (int i = 0; i < 8; i++)
         apply_stimulus(0, 5'b10001, 16'h0000, 16'h0200, 5'b0, 1,
                        mk(5'b10001, 16'h0000, 7'b0000110, 2'b00, 16'(9 - i), 16'h0001, 4'(7 - i), 1'b1, 1'b0));
      apply_stimulus(0, 5'b10001, 16'h0000, 16'h0200, 5'b0, 1, mk(5'b10001, 16'h0000, 7'b0000000, 2'b00, 16'h0, 16'h0001, 4'd0, 1'b1, 1'b1));

      // Back-pressure: LDI pending while execute stalls
      ldi_exp = mk(5'b11101, 16'hBEEF, 7'b1000000, 2'b01, 16'h0, 16'hBEEF, 4'd0, 1'b1, 1'b1);
      apply_stimulus(0, 5'b11101, 16'hBEEF, 16'h0300, 5'b0, 1, ldi_exp);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val("stall in_ready", 32'(in_ready0), 32'd0);
         check_val("stall out_valid", 32'(out_valid0), 32'd1);
         check_output("stall hold", act0, ldi_exp);
      end
      out_ready = 1'b1;
      @(negedge clk);

      // Reset while a bundle is pending and the stack is non-empty
      apply_stimulus(0, 5'b01101, 16'h0200, 16'h0030, 5'b0, 1, mk(5'b01101, 16'h0200, 7'b0000100, 2'b00, 16'h0200, 16'h0001, 4'd1, 1'b1, 1'b1));
      apply_stimulus(0, 5'b01000, 16'h0005, 16'h0031, 5'b0, 1, mk(5'b01000, 16'h0005, 7'b1010000, 2'b00, 16'h0, 16'h0001, 4'd1, 1'b1, 1'b1));
      out_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_val("mid reset out_valid", 32'(out_valid0), 32'd0);
      check_val("mid reset ras_count", 32'(ras_count0), 32'd0);
      check_val("mid reset ras_overflow", 32'(ras_overflow0), 32'd0);
      q0.delete();
      q1.delete();
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      apply_stimulus(0, 5'b01100, 16'h0000, 16'h0000, 5'b0, 1, mk(5'b01100, 16'h0000, 7'b1010000, 2'b00, 16'h0, 16'h0001, 4'd0, 1'b0, 1'b0));

      // One-slot squash instance: conditionals, squashes, loads/stores, RET after squash
      apply_stimulus(1, 5'b01010, 16'h0077, 16'h0000, 5'b00000, 1, mk(5'b01010, 16'h0077, 7'b0000000, 2'b00, 16'h0, 16'h0001, 4'd0, 1'b0, 1'b0));
      apply_stimulus(1, 5'b00001, 16'h0003, 16'h0001, 5'b00000, 1, mk(5'b00001, 16'h0003, 7'b1010001, 2'b01, 16'h0, 16'h0001, 4'd0, 1'b0, 1'b0));
      apply_stimulus(1, 5'b01010, 16'h0080, 16'h0002, 5'b10000, 1, mk(5'b01010, 16'h0080, 7'b0000100, 2'b00, 16'h0080, 16'h0001, 4'd0, 1'b0, 1'b0));
      apply_stimulus(1, 5'b00000, 16'h1111, 16'h0003, 5'b00000, 0, none);
      apply_stimulus(1, 5'b11001, 16'h0025, 16'h0080, 5'b00000, 1, mk(5'b11001, 16'h0025, 7'b0100000, 2'b00, 16'h0, 16'h0001, 4'd0, 1'b0, 1'b0));
      apply_stimulus(1, 5'b11010, 16'h03FF, 16'h0081, 5'b00000, 1, mk(5'b11010, 16'h03FF, 7'b0001000, 2'b00, 16'h0, 16'h0001, 4'd0, 1'b0, 1'b0));
      apply_stimulus(1, 5'b01011, 16'h0055, 16'h0082, 5'b00001, 1, mk(5'b01011, 16'h0055, 7'b0000100, 2'b00, 16'h0055, 16'h0001, 4'd0, 1'b0, 1'b0));
      apply_stimulus(1, 5'b11001, 16'h0001, 16'h0083, 5'b00000, 0, none);
      apply_stimulus(1, 5'b01110, 16'h0099, 16'h0055, 5'b00001, 1, mk(5'b01110, 16'h0099, 7'b0000000, 2'b00, 16'h0, 16'h0001, 4'd0, 1'b0, 1'b0));
      apply_stimulus(1, 5'b01111, 16'h0123, 16'h0050, 5'b00001, 1, mk(5'b01111, 16'h0123, 7'b0000100, 2'b00, 16'h0123, 16'h0001, 4'd1, 1'b0, 1'b0));
      apply_stimulus(1, 5'b10001, 16'h0000, 16'h0051, 5'b00000, 0, none);
      apply_stimulus(1, 5'b10001, 16'h0000, 16'h0123, 5'b00000, 1, mk(5'b10001, 16'h0000, 7'b0000110, 2'b00, 16'h0051, 16'h0001, 4'd0, 1'b0, 1'b0));
      apply_stimulus(1, 5'b00000, 16'h2222, 16'h0124, 5'b00000, 0, none);
      apply_stimulus(1, 5'b11100, 16'h00A5, 16'h0051, 5'b00000, 1, mk(5'b11100, 16'h00A5, 7'b1000000, 2'b00, 16'h0, 16'h00A5, 4'd0, 1'b0, 1'b0));

      for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
      repeat (2) @(negedge clk);
      check_val("scoreboard drained", 32'(q0.size() + q1.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/instruction_decode_stage.md
# instruction_decode_stage

Registered, parametrised instruction-decode stage between fetch and execute, generalising the combinational decoder. It adds valid/ready handshakes on both sides, a return-address stack (RAS) of configurable depth in place of the single link register, and a configurable post-branch squash counter. All control outputs are registered with exactly one cycle of latency.

## Interface
- DATA_W, 16, payload width; instruction is {op[4:0], payload[DATA_W-1:0]}
- ADDR_W, 16, instruction address width (ADDR_W <= DATA_W)
- REG_AW, 5, register-file address width
- MEM_AW, 10, data-memory address width
- RAS_DEPTH, 8, return-address stack entries (power of two, >= 2)
- SQUASH_SLOTS, 1, instructions discarded after a taken transfer (0..3)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept
- ins  in  DATA_W+5  instruction word
- ins_addr  in  ADDR_W  address of ins
- flags  in  5  {Z, CY, S, P, OV}, sampled on accept
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute consumes the bundle
- a_ce, regs_ce, flags_ce, mem_we, load_pc, pc_source, block_cy_ov  out  1 each
- arg_source  out  2
- opcode  out  3  ins[DATA_W+4:DATA_W+2]
- new_pc  out  ADDR_W
- regs_addr  out  REG_AW  payload[REG_AW-1:0]
- mem_addr  out  MEM_AW  payload[MEM_AW-1:0]
- instant  out  DATA_W
- ras_count  out  $clog2(RAS_DEPTH)+1  current stack occupancy
- ras_overflow, ras_underflow  out  1  sticky error flags

## Operation
- Accept when in_valid && in_ready; in_ready = !out_valid || out_ready.
- Decode classes by op (unlisted defaults: all enables 0, arg_source 00, instant 1):
  - ALU 00000/00100/01000/01100/10000/10100: a_ce=1, flags_ce=1.
  - INC/DEC 00001/00101: a_ce=1, flags_ce=1, arg_source=01, block_cy_ov=1.
  - JMP 01001, CALL 01101: load_pc=1, new_pc=payload[ADDR_W-1:0].
  - JZ 01010 / CALLZ 01110 taken if Z; JOV 01011 / CALLOV 01111 taken if OV; not taken = NOP.
  - RET 10001: load_pc=1, pc_source=1, new_pc=RAS top, pop.
  - LDI 11100/11101/11110: a_ce=1, instant=payload, arg_source=op[1:0].
  - LD 11001: regs_ce=1. ST 11010: mem_we=1.
  - Anything else: NOP, emitted with out_valid=1.
- RAS (circular, updated at accept):
  - Taken call pushes ins_addr+1 (mod 2^ADDR_W).
  - Push at count==RAS_DEPTH overwrites the oldest entry; count stays; ras_overflow set.
  - RET at count==0 emits NOP and sets ras_underflow; pointer and count unchanged.
- Squash: any accepted taken transfer (jump, call, RET) loads squash_cnt=SQUASH_SLOTS. While squash_cnt>0, each accept decrements it and drops the instruction: no output, no RAS or flag effect, in_ready unaffected.
- Sticky flags clear only on reset.

## Timing
- Reset: out_valid=0, all enables 0, arg_source=0, opcode/new_pc/regs_addr/mem_addr=0, instant=1, ras_count=0, sticky flags 0, squash_cnt=0, RAS pointer 0.
- Latency 1: accepted at edge k, bundle visible after edge k.
- Throughput 1/cycle with out_ready=1. Accept and consume in the same cycle is allowed.
- While out_valid && !out_ready, all outputs are held stable.
- RET directly after CALL sees the pushed address, with no bubble.
- Reset asserted mid-stream: pending bundle discarded, RAS emptied immediately.

## Test plan
- Reset, then ALU 00100 with out_ready=1 -> next cycle out_valid=1, a_ce=1, flags_ce=1, opcode=001, instant=1.
- CALL 01101 to 0x0040 at ins_addr 0x0010, then RET (SQUASH_SLOTS=0) -> load_pc=1 with new_pc=0x0040, then load_pc=1, pc_source=1, new_pc=0x0011; ras_count 1 then 0.
- JZ with Z=0 -> NOP and no squash. JZ with Z=1 -> load_pc=1, and the next accepted instruction (SQUASH_SLOTS=1) produces no out_valid.
- 9 calls with RAS_DEPTH=8 -> ras_overflow=1, ras_count=8; 8 RETs return addresses 9 down to 2; a 9th RET -> NOP, ras_underflow=1.
- Hold out_ready=0 for 3 cycles with LDI 11101 payload 0xBEEF pending -> in_ready=0 and outputs stable; on release, instant=0xBEEF, arg_source=01.
- Assert rst_n low while a bundle is pending -> out_valid=0 immediately, ras_count=0.
